// File: rtl/stage_one_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : stage_one_fetch
//  Description : Instruction-fetch stage. Owns the PC and issues word fetches
//                over a req/ready handshake. Delivers instruction + PC+4 to
//                decode through a registered IF/ID boundary with a one-entry
//                hold buffer. Applies decode's next-PC selection.
//                Optional return-address stack, enabled by the macro
//                FETCH_RAS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_one_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pc_src,
    input  logic        pc_write,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] jump_jpc,
    input  logic [31:0] branch_target,
    input  logic [31:0] reg_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic        ras_overflow,
    output logic        ras_underflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] addr_next;
    logic        flush;
    logic        flush_next;
    logic [31:0] instr_next;
    logic [31:0] pc4_next;
    logic        valid_next;
    logic        hold_valid;
    logic        hold_valid_next;
    logic [31:0] hold_instr;
    logic [31:0] hold_instr_next;
    logic [31:0] hold_pc4;
    logic [31:0] hold_pc4_next;
    logic        start_req;

    logic        redirect_sel;
    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        mem_done;
    logic        accept;
    logic        to_ifid;
    logic        to_hold;

`ifdef FETCH_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [31:0]      ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W:0]   ras_cnt;
    logic [PTR_W-1:0] ras_top_idx;
    logic             ras_empty;
    logic             ras_full;
    logic             do_push;
    logic             do_pop;
    logic [31:0]      ras_top;

    assign do_push     = push & pc_write;
    assign do_pop      = pop & pc_write;
    assign ras_top_idx = ras_ptr - PTR_W'(1);
    assign ras_empty   = (ras_cnt == '0);
    assign ras_full    = (ras_cnt == (PTR_W + 1)'(RAS_DEPTH));
    // An empty stack sends a pop back to the reset vector.
    assign ras_top     = ras_empty ? RESET_PC : ras_mem[ras_top_idx];

    // Stack pointer, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ras_ptr       <= '0;
            ras_cnt       <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (do_push && do_pop) begin
            // Pop reads old top, push replaces it: occupancy unchanged.
            if (ras_empty) begin
                ras_underflow <= 1'b1;
            end
        end else if (do_push) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_full) begin
                ras_overflow <= 1'b1;
            end else begin
                ras_cnt <= ras_cnt + (PTR_W + 1)'(1);
            end
        end else if (do_pop) begin
            if (ras_empty) begin
                ras_underflow <= 1'b1;
            end else begin
                ras_ptr <= ras_ptr - PTR_W'(1);
                ras_cnt <= ras_cnt - (PTR_W + 1)'(1);
            end
        end
    end

    // Stack storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push && do_pop) begin
            ras_mem[ras_top_idx] <= pc_plus4;
        end else if (do_push) begin
            ras_mem[ras_ptr] <= pc_plus4;
        end
    end
`else
    logic unused_ras;
    assign unused_ras    = ^{push, pop, (RAS_DEPTH > 0)};
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{jump_jpc[31:28], target_raw[1:0]};

    // Next-PC source decode; unsupported selects fall through to PC+4.
    always_comb begin
        redirect_sel = 1'b0;
        target_raw   = branch_target;
        case (pc_src)
            3'd1: begin
                redirect_sel = 1'b1;
                target_raw   = branch_target;
            end
            3'd2: begin
                redirect_sel = 1'b1;
                target_raw   = {pc_plus4[31:28], jump_jpc[27:0]};
            end
            3'd3: begin
                redirect_sel = 1'b1;
                target_raw   = reg_target;
            end
`ifdef FETCH_RAS_EN
            3'd4: begin
                redirect_sel = 1'b1;
                target_raw   = ras_top;
            end
`endif
            default: begin
                redirect_sel = 1'b0;
            end
        endcase
    end

    assign redirect = pc_write & redirect_sel;
    assign target   = {target_raw[31:2], 2'b00};

    // A response counts only while a request is actually outstanding.
    assign mem_done = imem_ready & (state == S_REQ);
    assign accept   = mem_done & ~flush & ~redirect;
    assign to_ifid  = accept & (~valid | pc_write);
    assign to_hold  = accept & valid & ~pc_write;
    assign imem_req = (state == S_REQ);

    // Next-state, PC, IF/ID and hold-buffer computation.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        addr_next       = imem_addr;
        flush_next      = flush;
        instr_next      = instruction;
        pc4_next        = pc_plus4;
        valid_next      = valid;
        hold_valid_next = hold_valid;
        hold_instr_next = hold_instr;
        hold_pc4_next   = hold_pc4;
        start_req       = 1'b0;

        if (redirect) begin
            pc_next = target;
        end else if (accept) begin
            pc_next = pc + 32'd4;
        end

        case (state)
            S_IDLE: begin
                state_next = S_REQ;
                start_req  = 1'b1;
            end
            S_REQ: begin
                if (mem_done) begin
                    flush_next = 1'b0;
                    if (to_hold) begin
                        state_next = S_HOLD;
                    end else begin
                        start_req = 1'b1;
                    end
                end else if (redirect) begin
                    // Request still in flight: its word must be discarded.
                    flush_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect || (pc_write && valid)) begin
                    state_next = S_REQ;
                    start_req  = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // The address of a new request is the PC it starts from; it then stays put.
        if (start_req) begin
            addr_next = pc_next;
        end

        if (redirect) begin
            valid_next      = 1'b0;
            hold_valid_next = 1'b0;
        end else begin
            if (pc_write && valid) begin
                if (hold_valid) begin
                    instr_next      = hold_instr;
                    pc4_next        = hold_pc4;
                    hold_valid_next = 1'b0;
                end else if (to_ifid) begin
                    instr_next = imem_rdata;
                    pc4_next   = imem_addr + 32'd4;
                end else begin
                    valid_next = 1'b0;
                end
            end else if (to_ifid) begin
                instr_next = imem_rdata;
                pc4_next   = imem_addr + 32'd4;
                valid_next = 1'b1;
            end
            if (to_hold) begin
                hold_valid_next = 1'b1;
                hold_instr_next = imem_rdata;
                hold_pc4_next   = imem_addr + 32'd4;
            end
        end
    end

    // State, PC, fetch address, IF/ID and hold-buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            imem_addr   <= RESET_PC;
            flush       <= 1'b0;
            instruction <= 32'h0000_0000;
            pc_plus4    <= 32'h0000_0000;
            valid       <= 1'b0;
            hold_valid  <= 1'b0;
            hold_instr  <= 32'h0000_0000;
            hold_pc4    <= 32'h0000_0000;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            imem_addr   <= addr_next;
            flush       <= flush_next;
            instruction <= instr_next;
            pc_plus4    <= pc4_next;
            valid       <= valid_next;
            hold_valid  <= hold_valid_next;
            hold_instr  <= hold_instr_next;
            hold_pc4    <= hold_pc4_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_one_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_one_fetch
//  Description : Directed self-checking bench for stage_one_fetch. Memory is
//                modelled as returning the fetch address as data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_one_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pc_src;
    logic        pc_write;
    logic        push;
    logic        pop;
    logic [31:0] jump_jpc;
    logic [31:0] branch_target;
    logic [31:0] reg_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr;

    stage_one_fetch #(
        .RESET_PC  (32'h0000_0000),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_src        (pc_src),
        .pc_write      (pc_write),
        .push          (push),
        .pop           (pop),
        .jump_jpc      (jump_jpc),
        .branch_target (branch_target),
        .reg_target    (reg_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .pc_plus4      (pc_plus4),
        .valid         (valid),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b0;
        pc_src        = 3'd0;
        pc_write      = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        jump_jpc      = 32'h0;
        branch_target = 32'h0;
        reg_target    = 32'h0;
        imem_ready    = 1'b0;

        // Reset state
        tick();
        tick();
        chk1("rst_req",   imem_req, 1'b0);
        chk1("rst_valid", valid, 1'b0);
        chk ("rst_instr", instruction, 32'h0);
        chk ("rst_pc4",   pc_plus4, 32'h0);
        chk ("rst_addr",  imem_addr, 32'h0);
        chk1("rst_ovf",   ras_overflow, 1'b0);
        chk1("rst_unf",   ras_underflow, 1'b0);

        // Zero-wait streaming after reset release
        pc_write   = 1'b1;
        imem_ready = 1'b1;
        rst        = 1'b1;
        tick();
        chk1("s0_req",   imem_req, 1'b1);
        chk ("s0_addr",  imem_addr, 32'h0);
        chk1("s0_valid", valid, 1'b0);
        tick();
        chk ("s1_instr", instruction, 32'h0);
        chk1("s1_valid", valid, 1'b1);
        chk ("s1_pc4",   pc_plus4, 32'h4);
        chk ("s1_addr",  imem_addr, 32'h4);
        tick();
        chk ("s2_instr", instruction, 32'h4);
        chk ("s2_addr",  imem_addr, 32'h8);
        tick();
        chk ("s3_instr", instruction, 32'h8);
        chk ("s3_pc4",   pc_plus4, 32'hC);
        chk ("s3_addr",  imem_addr, 32'hC);

        // Decode stalls three cycles; word 0xC goes to the hold buffer
        pc_write = 1'b0;
        tick();
        chk ("st0_instr", instruction, 32'h8);
        chk1("st0_req",   imem_req, 1'b0);
        tick();
        chk ("st1_instr", instruction, 32'h8);
        chk1("st1_req",   imem_req, 1'b0);
        tick();
        chk ("st2_instr", instruction, 32'h8);
        chk1("st2_req",   imem_req, 1'b0);
        pc_write = 1'b1;
        tick();
        chk ("drain_instr", instruction, 32'hC);
        chk ("drain_pc4",   pc_plus4, 32'h10);
        chk1("drain_valid", valid, 1'b1);
        chk1("drain_req",   imem_req, 1'b1);
        chk ("drain_addr",  imem_addr, 32'h10);
        tick();
        chk ("post_instr", instruction, 32'h10);
        chk ("post_addr",  imem_addr, 32'h14);

        // Branch to 0x1000_000C while memory responds (word dropped)
        pc_src        = 3'd1;
        branch_target = 32'h1000_000C;
        tick();
        chk ("br_addr",  imem_addr, 32'h1000_000C);
        chk1("br_valid", valid, 1'b0);
        pc_src = 3'd0;
        tick();
        chk ("br_instr", instruction, 32'h1000_000C);
        chk ("br_pc4",   pc_plus4, 32'h1000_0010);
        chk ("br_next",  imem_addr, 32'h1000_0010);

        // Jump while memory stalls two cycles: in-flight word flushed
        imem_ready = 1'b0;
        pc_src     = 3'd2;
        jump_jpc   = 32'h0000_0400;
        tick();
        chk1("j0_valid", valid, 1'b0);
        chk ("j0_addr",  imem_addr, 32'h1000_0010);
        chk1("j0_req",   imem_req, 1'b1);
        pc_src = 3'd0;
        tick();
        chk ("j1_addr",  imem_addr, 32'h1000_0010);
        chk1("j1_valid", valid, 1'b0);
        imem_ready = 1'b1;
        tick();
        chk ("j2_addr",  imem_addr, 32'h1000_0400);
        chk1("j2_valid", valid, 1'b0);
        tick();
        chk ("j3_instr", instruction, 32'h1000_0400);
        chk ("j3_pc4",   pc_plus4, 32'h1000_0404);

        // Register redirect with low bits set, then PC wrap-around
        pc_src     = 3'd3;
        reg_target = 32'hFFFF_FFFF;
        tick();
        chk ("rg_addr", imem_addr, 32'hFFFF_FFFC);
        pc_src = 3'd5;
        tick();
        chk ("wrap_instr", instruction, 32'hFFFF_FFFC);
        chk ("wrap_pc4",   pc_plus4, 32'h0);
        chk ("wrap_addr",  imem_addr, 32'h0);
        tick();
        chk ("src5_instr", instruction, 32'h0);
        chk ("src5_addr",  imem_addr, 32'h4);
        chk1("src5_valid", valid, 1'b1);
        pc_src = 3'd0;

`ifndef FETCH_RAS_EN
        // Without the stack, pc_src 4 and push/pop are inert
        pc_src = 3'd4;
        push   = 1'b1;
        pop    = 1'b1;
        tick();
        chk ("nr_instr", instruction, 32'h4);
        chk ("nr_addr",  imem_addr, 32'h8);
        chk1("nr_valid", valid, 1'b1);
        chk1("nr_ovf",   ras_overflow, 1'b0);
        chk1("nr_unf",   ras_underflow, 1'b0);
        pc_src = 3'd0;
        push   = 1'b0;
        pop    = 1'b0;
`else
        // Call/return through the stack
        pc_src        = 3'd1;
        branch_target = 32'h20;
        tick();
        pc_src = 3'd0;
        tick();
        chk ("cl_pc4", pc_plus4, 32'h24);
        push = 1'b1;
        tick();
        push = 1'b0;
        tick();
        chk ("cl_instr", instruction, 32'h28);
        pop    = 1'b1;
        pc_src = 3'd4;
        tick();
        chk ("ret_addr", imem_addr, 32'h24);
        chk1("ret_unf",  ras_underflow, 1'b0);
        pop    = 1'b0;
        pc_src = 3'd0;
        tick();
        chk ("ret_instr", instruction, 32'h24);
        chk ("ret_pc4",   pc_plus4, 32'h28);

        // Five pushes (0x28..0x38) into a four-deep stack
        push = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk1("p4_ovf", ras_overflow, 1'b0);
        tick();
        chk1("p5_ovf", ras_overflow, 1'b1);
        chk ("p5_pc4", pc_plus4, 32'h3C);
        push   = 1'b0;
        pop    = 1'b1;
        pc_src = 3'd4;
        tick();
        chk ("pop_e", imem_addr, 32'h38);
        tick();
        chk ("pop_d", imem_addr, 32'h34);
        tick();
        chk ("pop_c", imem_addr, 32'h30);
        tick();
        chk ("pop_b", imem_addr, 32'h2C);
        chk1("pop_b_unf", ras_underflow, 1'b0);
        tick();
        chk ("pop_empty", imem_addr, 32'h0);
        chk1("pop_unf",   ras_underflow, 1'b1);
        chk1("pop_ovf",   ras_overflow, 1'b1);
        pop    = 1'b0;
        pc_src = 3'd0;
        tick();
        chk ("pop_instr", instruction, 32'h0);
`endif

        // Asynchronous reset in the middle of an outstanding request
        chk1("ar_pre_req", imem_req, 1'b1);
        imem_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk1("ar_req",   imem_req, 1'b0);
        chk1("ar_valid", valid, 1'b0);
        chk ("ar_instr", instruction, 32'h0);
        chk ("ar_pc4",   pc_plus4, 32'h0);
        chk ("ar_addr",  imem_addr, 32'h0);
        chk1("ar_ovf",   ras_overflow, 1'b0);
        chk1("ar_unf",   ras_underflow, 1'b0);
        #1;
        imem_ready = 1'b1;
        rst        = 1'b1;
        tick();
        chk1("rr_req",   imem_req, 1'b1);
        chk ("rr_addr",  imem_addr, 32'h0);
        chk1("rr_valid", valid, 1'b0);
        tick();
        chk ("rr_instr", instruction, 32'h0);
        chk1("rr_valid2", valid, 1'b1);
        chk ("rr_pc4",   pc_plus4, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_one_fetch.md
# stage_one_fetch

Instruction-fetch stage of the five-stage core, sitting directly upstream of the decode stage. Owns the program counter, issues word fetches to instruction memory over a request/ready handshake, and presents the fetched instruction plus its PC+4 to decode through a registered IF/ID boundary. Applies decode's next-PC selection (`pc_src`, `pc_write`, `jump_jpc`) and keeps a small hardware return-address stack driven by decode's `push`/`pop` strobes.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `RAS_DEPTH`, 4, return-address stack entries (power of two, 2..16).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_src`  in  3  next-PC select from decode: 0 PC+4, 1 branch, 2 jump, 3 register, 4 stack pop; 5–7 behave as 0.
- `pc_write`  in  1  decode accepts the current instruction; the PC may advance or redirect.
- `push`  in  1  push `pc_plus4` onto the return stack (qualified by `pc_write`).
- `pop`  in  1  pop the return stack (qualified by `pc_write`).
- `jump_jpc`  in  32  word-shifted jump field from decode.
- `branch_target`  in  32  computed branch address.
- `reg_target`  in  32  register-indirect target.
- `imem_req`  out  1  fetch request; held until `imem_ready`.
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high.
- `imem_ready`  in  1  `imem_rdata` valid this cycle; completes the request.
- `imem_rdata`  in  32  fetched word.
- `instruction`  out  32  IF/ID instruction register.
- `pc_plus4`  out  32  address of `instruction` plus 4.
- `valid`  out  1  `instruction` is live.
- `ras_overflow`  out  1  sticky: a push overwrote the oldest entry.
- `ras_underflow`  out  1  sticky: a pop hit an empty stack.

## Operation
- Reset (`rst` low, asynchronous): PC = `RESET_PC`. `instruction` = 0 (NOP), `pc_plus4` = 0, `valid` = 0, `imem_req` = 0. Hold buffer, flush flag, stack pointer, count and both sticky flags are cleared.
- FSM states and transitions:
  - IDLE → REQ on the first clock after reset release.
  - REQ: `imem_req` = 1, `imem_addr` = PC.
  - REQ → REQ when `imem_ready` is returned and the word was accepted.
  - REQ → HOLD when `imem_ready` is returned but the word went to the hold buffer.
  - HOLD: no request is issued. HOLD → REQ when the hold buffer drains or a redirect occurs.
- Word acceptance on `imem_ready`:
  - If the flush flag is set: the word is dropped, the flag clears, and PC is unchanged.
  - Else, if IF/ID is empty (`valid` = 0) or is being consumed (`pc_write` = 1): the word loads IF/ID, `pc_plus4` = `imem_addr` + 4, `valid` = 1, and PC += 4.
  - Else: the word and its address go to the one-entry hold buffer, and PC += 4.
- Consume (`pc_write` = 1 with `valid` = 1) and no redirect:
  - IF/ID reloads from the hold buffer if it is full.
  - Otherwise IF/ID loads from the same-cycle `imem_ready` word.
  - Otherwise `valid` goes to 0.
- Redirect (`pc_write` = 1 and `pc_src` in 1..4). The target is taken from:
  - 1: `branch_target`.
  - 2: {`pc_plus4`[31:28], `jump_jpc`[27:0]}.
  - 3: `reg_target`.
  - 4: the stack top.
- On redirect, at the clock edge:
  - PC = target, `valid` = 0, hold buffer cleared.
  - If a request is outstanding and `imem_ready` is low this cycle, the flush flag is set.
  - If `imem_ready` is high in the redirect cycle, that word is dropped.
- Return stack:
  - A push writes `pc_plus4` at the top and increments the pointer modulo `RAS_DEPTH`.
  - A push while full overwrites the oldest entry and sets `ras_overflow`.
  - A pop reads the top and decrements the pointer.
  - A pop while empty yields a target of `RESET_PC` and sets `ras_underflow`.
  - Push and pop in the same cycle: the pop reads the old top, then the push replaces it. Pointer and count are unchanged.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0. Bits [1:0] of every target are forced to 0.

## Timing
- Earliest `imem_req` is in the first cycle after `rst` rises.
- `imem_ready` in cycle N → `instruction`/`valid` are visible in cycle N+1. With zero-wait memory, this gives one instruction per cycle.
- A redirect in cycle N → `imem_addr` = target in cycle N+1, or once the flushed request completes.
- `imem_addr` and `imem_req` are registered outputs and never change while waiting for `imem_ready`.
- `rst` asserted mid-request forces the reset state immediately. A late `imem_ready` after reset release, with no request outstanding, is ignored.

## Configuration
- `FETCH_RAS_EN` defined: the return stack, `push`, `pop`, `pc_src` = 4 and both sticky flags operate as specified.
- `FETCH_RAS_EN` undefined:
  - No stack storage is built; `push` and `pop` are ignored.
  - `pc_src` = 4 behaves as 0.
  - `ras_overflow` and `ras_underflow` are tied to 0.

## Test plan
- Reset release with zero-wait memory returning `imem_addr` as data → `imem_addr` sequence 0, 4, 8. `instruction` = 0, 4, 8 on consecutive cycles. `valid` is 1 from the second cycle onward.
- `pc_write` held 0 for 3 cycles while memory responds → IF/ID holds its word, the hold buffer captures the next word, and no further `imem_req`. On release, the words are delivered in order with no loss or duplicate.
- Jump with `pc_plus4` = 32'h1000_0010 and `jump_jpc` = 32'h0000_0400, while memory stalls 2 cycles → the in-flight word is dropped and the next `imem_addr` = 32'h1000_0400.
- Push at `pc_plus4` = 32'h24, then later a pop with `pc_src` = 4 → the fetch resumes at 32'h24.
- With `RAS_DEPTH` = 4: five pushes (A..E) then five pops → targets E, D, C, B, then `RESET_PC`. `ras_overflow` = 1 and `ras_underflow` = 1.
- `rst` pulsed low while `imem_req` = 1 → outputs reset within the same cycle, and the first post-release fetch address is `RESET_PC`.
